valu_alu: RTL and testbench
===========================

Name: valu_alu

Overview:
32-bit registered arithmetic/logic unit for the vALU datapath. It selects one of eight operations with a 3-bit opcode. The result and status flags (Zero, Overflow, Cout) are captured in output registers on each rising clock edge. It sits between the register-file read ports and the writeback/branch-condition logic.

Parameters:
WIDTH, 32, operand and result width in bits. All behaviour below is written for 32; the design must remain correct for any WIDTH >= 2.

Ports:
clk  input  1  single system clock; all state updates on the rising edge
rst_n  input  1  asynchronous, active-low reset
S  input  3  operation select
A  input  WIDTH  operand A
B  input  WIDTH  operand B
out  output  WIDTH  registered result
Zero  output  1  registered; 1 when the registered result is all zeros
Overflow  output  1  registered two's-complement signed overflow flag
Cout  output  1  registered carry-out of the adder

Behaviour:
- Structure: combinational op stage, then a single register bank holding out, Zero, Overflow and Cout. Latency is exactly 1 cycle: inputs sampled at edge N appear on the outputs after edge N. There is no handshake; a new operation is accepted every cycle.
- Reset: when rst_n=0, the registers clear immediately, regardless of clk. Reset values: out=0, Zero=1, Overflow=0, Cout=0. Registers hold these values until the first rising edge with rst_n=1. Deasserting reset mid-operation has no side effects; the next edge simply captures the current inputs.
- Opcodes for S:
  - 000 ADD: out = A + B (mod 2^WIDTH). Cout = carry out of the MSB. Overflow = A[msb]==B[msb] && out[msb]!=A[msb].
  - 001 SUB: out = A + ~B + 1. Cout = carry out of the MSB, so 1 means no borrow (A >= B unsigned). Overflow = A[msb]!=B[msb] && out[msb]!=A[msb].
  - 010 XOR: out = A ^ B.
  - 011 SLT: out = 1 if signed(A) < signed(B), else 0. Computed as (SUB result sign) XOR (SUB overflow); upper bits are zero.
  - 100 AND: out = A & B.
  - 101 NAND: out = ~(A & B).
  - 110 NOR: out = ~(A | B).
  - 111 OR: out = A | B.
- Flag rules:
  - Cout and Overflow are forced to 0 for all opcodes other than ADD and SUB, including SLT.
  - Zero = (next out == 0) for every opcode, registered alongside out.
- Arithmetic is two's complement with wrap-around; there is no saturation or exception.
- The adder is a single WIDTH-bit ripple or carry-lookahead adder shared by ADD, SUB and SLT; B is inverted and carry-in is set to 1 for SUB and SLT.
- X/Z on inputs is not required to be handled; the outputs must not be X after reset when the inputs are known.

Test Plan:
- Reset: rst_n=0 with inputs arbitrary -> out=0x00000000, Zero=1, Overflow=0, Cout=0, without a clock edge. Release rst_n, set A=0, B=0, S=000, one edge -> out=0, Zero=1, Cout=0, Overflow=0.
- ADD boundaries, S=000:
  - A=0x7FFFFFFF, B=1 -> out=0x80000000, Overflow=1, Cout=0, Zero=0.
  - A=0xFFFFFFFF, B=1 -> out=0, Cout=1, Overflow=0, Zero=1.
- SUB, S=001:
  - A=5, B=5 -> out=0, Zero=1, Cout=1.
  - A=0x80000000, B=1 -> out=0x7FFFFFFF, Overflow=1, Cout=1.
  - A=0, B=1 -> out=0xFFFFFFFF, Cout=0.
- SLT, S=011:
  - A=0xFFFFFFFF (-1), B=1 -> out=1, Cout=0, Overflow=0.
  - A=0x80000000, B=0x7FFFFFFF -> out=1.
  - A=3, B=3 -> out=0, Zero=1.
- Logic ops, A=0xF0F0F0F0, B=0xFF00FF00:
  - XOR -> 0x0FF00FF0
  - AND -> 0xF000F000
  - NAND -> 0x0FFF0FFF
  - NOR -> 0x000F000F
  - OR -> 0xFFF0FFF0
  - Flags for all: Cout=0, Overflow=0.
- Latency/async reset: change inputs every cycle and check each result appears exactly one edge later. Assert rst_n low between edges mid-stream -> outputs clear immediately; the first edge after release captures the current inputs.

Source files
------------

// File: rtl/valu_alu.sv
// Registered 32-bit ALU: one shared adder for ADD/SUB/SLT, bitwise logic ops,
// and a single output register bank holding the result with Zero/Overflow/Cout.
module valu_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       S,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] out,
    output logic             Zero,
    output logic             Overflow,
    output logic             Cout
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_SLT  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_OR   = 3'b111;

    localparam int MSB = WIDTH - 1;

    logic             is_sub;
    logic [WIDTH-1:0] b_operand;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] add_sum;
    logic             add_carry;
    logic             add_ovf;
    logic             slt_bit;

    logic [WIDTH-1:0] next_out;
    logic             next_ovf;
    logic             next_cout;
    logic             next_zero;

    // SLT reuses the subtract path: B inverted, carry-in of one.
    assign is_sub    = (S == OP_SUB) || (S == OP_SLT);
    assign b_operand = is_sub ? ~B : B;
    assign add_full  = {1'b0, A} + {1'b0, b_operand} + {{WIDTH{1'b0}}, is_sub};
    assign add_sum   = add_full[WIDTH-1:0];
    assign add_carry = add_full[WIDTH];

    // Comparing against the (possibly inverted) adder input covers both ADD and SUB rules.
    assign add_ovf = (A[MSB] == b_operand[MSB]) && (add_sum[MSB] != A[MSB]);
    assign slt_bit = add_sum[MSB] ^ add_ovf;

    always_comb begin
        next_out  = '0;
        next_ovf  = 1'b0;
        next_cout = 1'b0;
        case (S)
            OP_ADD: begin
                next_out  = add_sum;
                next_ovf  = add_ovf;
                next_cout = add_carry;
            end
            OP_SUB: begin
                next_out  = add_sum;
                next_ovf  = add_ovf;
                next_cout = add_carry;
            end
            OP_XOR:  next_out = A ^ B;
            OP_SLT:  next_out = {{(WIDTH-1){1'b0}}, slt_bit};
            OP_AND:  next_out = A & B;
            OP_NAND: next_out = ~(A & B);
            OP_NOR:  next_out = ~(A | B);
            OP_OR:   next_out = A | B;
            default: next_out = '0;
        endcase
    end

    assign next_zero = (next_out == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out      <= '0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
            Cout     <= 1'b0;
        end else begin
            out      <= next_out;
            Zero     <= next_zero;
            Overflow <= next_ovf;
            Cout     <= next_cout;
        end
    end

endmodule

// File: tb/tb_valu_alu.sv
// Directed bench for valu_alu: the driver pushes hand-computed results into a
// queue and a monitor pops and compares one entry per clock edge.
module tb_valu_alu;

    localparam int WIDTH = 32;
    localparam int EW    = WIDTH + 3;  // {out, Zero, Overflow, Cout}

    logic             clk;
    logic             rst_n;
    logic [2:0]       S;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] out;
    logic             Zero;
    logic             Overflow;
    logic             Cout;

    logic [EW-1:0] exp_q[$];
    string         name_q[$];
    int            checks;
    int            failures;

    valu_alu #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .S        (S),
        .A        (A),
        .B        (B),
        .out      (out),
        .Zero     (Zero),
        .Overflow (Overflow),
        .Cout     (Cout)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic compare(input string name, input logic [EW-1:0] got, input logic [EW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got out=%h Z=%b V=%b C=%b, expected out=%h Z=%b V=%b C=%b",
                     name, got[EW-1:3], got[2], got[1], got[0],
                     exp[EW-1:3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Driver: inputs change on the falling edge, captured at the next rising edge.
    task automatic drive(input string name, input logic [2:0] s, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] e_out,
                         input logic e_z, input logic e_v, input logic e_c);
        @(negedge clk);
        S = s;
        A = a;
        B = b;
        exp_q.push_back({e_out, e_z, e_v, e_c});
        name_q.push_back(name);
    endtask

    // Monitor: every rising edge out of reset delivers one result.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && exp_q.size() > 0) begin
                logic [EW-1:0] e;
                string         n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                compare(n, {out, Zero, Overflow, Cout}, e);
            end
        end
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        S        = 3'b101;
        A        = 32'hDEADBEEF;
        B        = 32'h12345678;

        // Async reset with no clock edge
        #1 rst_n = 1'b0;
        #1 compare("reset_async", {out, Zero, Overflow, Cout}, {32'h0, 3'b100});
        @(posedge clk);
        #1 compare("reset_hold", {out, Zero, Overflow, Cout}, {32'h0, 3'b100});

        // Release with zero operands
        @(negedge clk);
        S = 3'b000; A = '0; B = '0;
        exp_q.push_back({32'h0, 3'b100});
        name_q.push_back("add_zero_after_reset");
        rst_n = 1'b1;

        drive("add_pos_ovf",  3'b000, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0);
        drive("add_wrap",     3'b000, 32'hFFFFFFFF, 32'h1, 32'h00000000, 1'b1, 1'b0, 1'b1);
        drive("sub_equal",    3'b001, 32'h5, 32'h5, 32'h00000000, 1'b1, 1'b0, 1'b1);
        drive("sub_neg_ovf",  3'b001, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);
        drive("sub_borrow",   3'b001, 32'h0, 32'h1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        drive("slt_m1_lt_1",  3'b011, 32'hFFFFFFFF, 32'h1, 32'h00000001, 1'b0, 1'b0, 1'b0);
        drive("slt_min_max",  3'b011, 32'h80000000, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0);
        drive("slt_equal",    3'b011, 32'h3, 32'h3, 32'h00000000, 1'b1, 1'b0, 1'b0);
        drive("slt_max_min",  3'b011, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1, 1'b0, 1'b0);
        drive("xor",          3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0, 1'b0);
        drive("and",          3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, 1'b0);
        drive("nand",         3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0, 1'b0);
        drive("nor",          3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0, 1'b0);
        drive("or",           3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);
        drive("nand_all_one", 3'b101, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0);

        // Back-to-back stream: each result must land exactly one edge later
        drive("stream_add",   3'b000, 32'h1, 32'h2, 32'h00000003, 1'b0, 1'b0, 1'b0);
        drive("stream_sub",   3'b001, 32'hA, 32'h3, 32'h00000007, 1'b0, 1'b0, 1'b1);
        drive("stream_or",    3'b111, 32'h0F, 32'hF0, 32'h000000FF, 1'b0, 1'b0, 1'b0);
        drive("stream_and",   3'b100, 32'h0F, 32'hF0, 32'h00000000, 1'b1, 1'b0, 1'b0);
        drive("stream_add_n", 3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b1, 1'b1);
        drive("stream_xor",   3'b010, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b0, 1'b0);

        // Mid-stream reset between edges: the in-flight vector is discarded
        drive("discarded",    3'b000, 32'h10, 32'h20, 32'h00000030, 1'b0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        name_q.delete();
        #1 compare("reset_mid_async", {out, Zero, Overflow, Cout}, {32'h0, 3'b100});
        @(posedge clk);
        #1 compare("reset_mid_hold", {out, Zero, Overflow, Cout}, {32'h0, 3'b100});

        // First edge after release captures the inputs present then
        drive("post_reset_xor", 3'b010, 32'hAAAAAAAA, 32'h55555555, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        drive("post_reset_sub", 3'b001, 32'h1, 32'h2, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        // Drain with a bounded wait
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d results still pending, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
